writeback_unit: RTL and testbench

//  Final pipeline stage; drives the register bank write port (write_end, write_in, RegWrite).
//  - Accepts retiring instructions via a valid/ready handshake.
//  - For loads: waits for the memory response, then extracts and sign/zero-extends the byte, half or word.
//  - Meets the bank's write timing: the bank samples address/flag at posedge and writes data at the following negedge.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/writeback_unit_if.sv | 30 +++
 rtl/writeback_unit_load_align.sv | 29 ++
 rtl/writeback_unit.sv | 150 +++++++++++++++
 tb/tb_writeback_unit.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback stage: load sizes, FSM states,
// the hard-wired zero register index and the load alignment rule.
package wb_pkg;

  typedef enum logic [1:0] {
    LS_BYTE = 2'd0,
    LS_HALF = 2'd1,
    LS_WORD = 2'd2
  } load_size_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  localparam int unsigned REG_ZERO = 0;

  // Halves need an even offset, words need offset 0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (load_size_t'(size))
      LS_HALF: return off[0];
      LS_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Retire-side handshake and memory-response bundle feeding the writeback unit.
// master drives instructions and load data; slave is the writeback unit.
interface writeback_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic              in_regwrite;
  logic              in_is_load;
  logic [1:0]        in_load_size;
  logic              in_load_unsigned;
  logic [1:0]        in_byte_off;
  logic [DATA_W-1:0] in_alu_result;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output in_valid, in_rd, in_regwrite, in_is_load, in_load_size,
           in_load_unsigned, in_byte_off, in_alu_result, mem_rvalid, mem_rdata,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd, in_regwrite, in_is_load, in_load_size,
           in_load_unsigned, in_byte_off, in_alu_result, mem_rvalid, mem_rdata,
    output in_ready
  );
endinterface

// File: rtl/writeback_unit_load_align.sv
// Combinational load lane selection: picks the byte/half/word out of the raw
// memory word and sign- or zero-extends it to the register width.
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  load_size_t        size,
  input  logic [1:0]        off,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{off, 3'b000} +: 8];
    half_lane = rdata[{off[1], 4'b0000} +: 16];
    data      = rdata;
    case (size)
      LS_BYTE: data = {{(DATA_W-8){~is_unsigned & byte_lane[7]}}, byte_lane};
      LS_HALF: data = {{(DATA_W-16){~is_unsigned & half_lane[15]}}, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage driving the register bank write port; data trails the
// address/enable by one cycle. Define WB_BYPASS_EN to add forwarding outputs.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  writeback_unit_if.slave   wb,
  output logic [ADDR_W-1:0] write_end,
  output logic [DATA_W-1:0] write_in,
  output logic              RegWrite,
  output logic              misalign,
  output logic [31:0]       retire_count
`ifdef WB_BYPASS_EN
  ,
  output logic              bypass_valid,
  output logic [ADDR_W-1:0] bypass_rd,
  output logic [DATA_W-1:0] bypass_data
`endif
);

  wb_state_t         state_q, state_d;
  logic [ADDR_W-1:0] lat_rd;
  load_size_t        lat_size;
  logic [1:0]        lat_off;
  logic              lat_uns;
  logic              lat_write;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] aligned;

  logic              transfer;
  logic              in_writes;
  logic              issue;
  logic [ADDR_W-1:0] issue_rd;
  logic [DATA_W-1:0] issue_data;
  logic              retire;
  logic              misalign_d;
  logic              latch_load;

  assign wb.in_ready = (state_q == IDLE);
  assign transfer    = wb.in_valid & (state_q == IDLE);
  assign in_writes   = wb.in_regwrite & (wb.in_rd != ADDR_W'(REG_ZERO));

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata       (wb.mem_rdata),
    .size        (lat_size),
    .off         (lat_off),
    .is_unsigned (lat_uns),
    .data        (aligned)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Loads that write nothing retire at transfer; others retire when the write issues.
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    issue_rd   = lat_rd;
    issue_data = aligned;
    retire     = 1'b0;
    misalign_d = 1'b0;
    latch_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (wb.in_is_load) begin
            if (is_misaligned(wb.in_load_size, wb.in_byte_off)) begin
              misalign_d = 1'b1;
            end else begin
              state_d    = WAIT_MEM;
              latch_load = 1'b1;
              retire     = ~in_writes;
            end
          end else begin
            retire     = 1'b1;
            issue      = in_writes;
            issue_rd   = wb.in_rd;
            issue_data = wb.in_alu_result;
          end
        end
      end
      WAIT_MEM: begin
        if (wb.mem_rvalid) begin
          state_d = IDLE;
          issue   = lat_write;
          retire  = lat_write;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lat_rd    <= '0;
      lat_size  <= LS_BYTE;
      lat_off   <= '0;
      lat_uns   <= 1'b0;
      lat_write <= 1'b0;
    end else if (latch_load) begin
      lat_rd    <= wb.in_rd;
      lat_size  <= load_size_t'(wb.in_load_size);
      lat_off   <= wb.in_byte_off;
      lat_uns   <= wb.in_load_unsigned;
      lat_write <= in_writes;
    end
  end

  // data_q parks the value for one cycle so write_in lands a cycle behind write_end.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite     <= 1'b0;
      write_end    <= '0;
      write_in     <= '0;
      data_q       <= '0;
      misalign     <= 1'b0;
      retire_count <= '0;
    end else begin
      RegWrite <= issue;
      misalign <= misalign_d;
      if (issue) begin
        write_end <= issue_rd;
        data_q    <= issue_data;
      end
      if (RegWrite) write_in <= data_q;
      if (retire)   retire_count <= retire_count + 32'd1;
    end
  end

`ifdef WB_BYPASS_EN
  logic data_cycle;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) data_cycle <= 1'b0;
    else          data_cycle <= RegWrite;
  end

  // write_end holds between writes, so it names the youngest uncommitted write.
  assign bypass_valid = RegWrite | data_cycle;
  assign bypass_rd    = write_end;
  assign bypass_data  = RegWrite ? data_q : write_in;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed scenarios then random traffic,
// checked against a behavioural register-file / load-extraction model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  writeback_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  logic [ADDR_W-1:0] write_end;
  logic [DATA_W-1:0] write_in;
  logic              reg_write;
  logic              misalign;
  logic [31:0]       retire_count;
`ifdef WB_BYPASS_EN
  logic              bypass_valid;
  logic [ADDR_W-1:0] bypass_rd;
  logic [DATA_W-1:0] bypass_data;
`endif

  writeback_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .wb           (wb),
    .write_end    (write_end),
    .write_in     (write_in),
    .RegWrite     (reg_write),
    .misalign     (misalign),
    .retire_count (retire_count)
`ifdef WB_BYPASS_EN
    ,
    .bypass_valid (bypass_valid),
    .bypass_rd    (bypass_rd),
    .bypass_data  (bypass_data)
`endif
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
  } exp_wr_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  exp_wr_t     wr_q[$];
  int          mis_q[$];
  logic [31:0] ref_regs[32];
  logic [31:0] bank[32];
  int          ref_retire = 0;

  logic [4:0]  ld_rd;
  bit          ld_write;
  int          ld_size, ld_off;
  bit          ld_uns;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got 0x%08h, expected nothing", name, actual);
  endtask

  function automatic bit ref_misaligned(input int size, input int off);
    return (size == 1 && (off % 2) == 1) || (size == 2 && off != 0);
  endfunction

  // Lane value by shifting/modulo, then two's-complement extension by subtraction.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int size,
                                           input int off, input bit uns);
    longint lane, width, base;
    lane = {32'b0, rdata};
    if (size == 0)      begin width = 8;  base = off; end
    else if (size == 1) begin width = 16; base = (off / 2) * 2; end
    else                begin width = 32; base = 0; end
    lane = (lane >> (8 * base)) % (longint'(1) << width);
    if (!uns && width < 32 && lane >= (longint'(1) << (width - 1)))
      lane = lane - (longint'(1) << width);
    return lane[31:0];
  endfunction

  task automatic drive_idle();
    wb.in_valid   = 1'b0;
    wb.mem_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      drive_idle();
    end
  endtask

  task automatic apply_stimulus(input bit is_load, input bit regwrite, input logic [4:0] rd,
                                input int size, input int off, input bit uns,
                                input logic [31:0] alu);
    @(negedge clock);
    check_output("in_ready before issue", 32'(wb.in_ready), 32'd1);
    wb.in_valid         = 1'b1;
    wb.in_rd            = rd;
    wb.in_regwrite      = regwrite;
    wb.in_is_load       = is_load;
    wb.in_load_size     = 2'(size);
    wb.in_load_unsigned = uns;
    wb.in_byte_off      = 2'(off);
    wb.in_alu_result    = alu;
    wb.mem_rvalid       = 1'b0;
    if (!is_load) begin
      ref_retire++;
      if (regwrite && rd != 0) begin
        wr_q.push_back('{rd, alu, cyc + 1});
        ref_regs[rd] = alu;
      end
    end else if (ref_misaligned(size, off)) begin
      mis_q.push_back(cyc + 1);
    end else begin
      ld_rd    = rd;
      ld_size  = size;
      ld_off   = off;
      ld_uns   = uns;
      ld_write = regwrite && rd != 0;
      if (!ld_write) ref_retire++;
    end
    @(posedge clock);
  endtask

  task automatic mem_respond(input int delay, input logic [31:0] rdata);
    logic [31:0] value;
    repeat (delay) begin
      @(negedge clock);
      drive_idle();
      check_output("in_ready while waiting", 32'(wb.in_ready), 32'd0);
    end
    @(negedge clock);
    wb.in_valid   = 1'b0;
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = rdata;
    check_output("in_ready at response", 32'(wb.in_ready), 32'd0);
    if (ld_write) begin
      value = ref_load(rdata, ld_size, ld_off, ld_uns);
      wr_q.push_back('{ld_rd, value, cyc + 1});
      ref_regs[ld_rd] = value;
      ref_retire++;
    end
    @(negedge clock);
    drive_idle();
    check_output("in_ready after response", 32'(wb.in_ready), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every RegWrite/misalign and models the bank.
  logic        pend = 1'b0;
  logic [4:0]  pend_rd;
  logic [31:0] pend_data;
  logic [31:0] last_wi = '0;
  always @(negedge clock) begin
    exp_wr_t e;
    bit      was_pend;
    int      m;
    if (!reset_n) begin
      pend    = 1'b0;
      last_wi = '0;
    end else begin
      was_pend = pend;
      if (pend) begin
        check_output("write_in data", write_in, pend_data);
        bank[pend_rd] = write_in;
        pend = 1'b0;
      end else begin
        check_output("write_in hold", write_in, last_wi);
      end
      last_wi = write_in;
`ifdef WB_BYPASS_EN
      if (!reg_write && was_pend) begin
        check_output("bypass_valid data cycle", 32'(bypass_valid), 32'd1);
        check_output("bypass_rd data cycle", 32'(bypass_rd), 32'(pend_rd));
        check_output("bypass_data data cycle", bypass_data, pend_data);
      end else if (!reg_write) begin
        check_output("bypass_valid idle", 32'(bypass_valid), 32'd0);
      end
`endif
      if (reg_write) begin
        if (wr_q.size() == 0) begin
          flag_fail("unexpected RegWrite", 32'(write_end));
        end else begin
          e = wr_q.pop_front();
          check_output("write_end", 32'(write_end), 32'(e.rd));
          check_output("RegWrite cycle", cyc, e.cyc);
          pend      = 1'b1;
          pend_rd   = write_end;
          pend_data = e.data;
`ifdef WB_BYPASS_EN
          check_output("bypass_valid issue", 32'(bypass_valid), 32'd1);
          check_output("bypass_rd issue", 32'(bypass_rd), 32'(e.rd));
          check_output("bypass_data issue", bypass_data, e.data);
`endif
        end
      end
      if (misalign) begin
        if (mis_q.size() == 0) begin
          flag_fail("unexpected misalign", 32'(cyc));
        end else begin
          m = mis_q.pop_front();
          check_output("misalign cycle", cyc, m);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rdata;
    for (int r = 0; r < 32; r++) begin
      ref_regs[r] = '0;
      bank[r]     = '0;
    end
    wb.in_rd = '0; wb.in_regwrite = 1'b0; wb.in_is_load = 1'b0; wb.in_load_size = '0;
    wb.in_load_unsigned = 1'b0; wb.in_byte_off = '0; wb.in_alu_result = '0; wb.mem_rdata = '0;
    drive_idle();

    reset_n = 1'b0;
    idle(3);
    check_output("reset RegWrite", 32'(reg_write), 32'd0);
    check_output("reset write_end", 32'(write_end), 32'd0);
    check_output("reset write_in", write_in, 32'd0);
    check_output("reset misalign", 32'(misalign), 32'd0);
    check_output("reset retire_count", retire_count, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle(1);
    check_output("in_ready after reset", 32'(wb.in_ready), 32'd1);

    $display("[TB] single ALU write");
    apply_stimulus(0, 1, 5'd5, 0, 0, 0, 32'hDEADBEEF);
    idle(3);
    check_output("retire_count alu", retire_count, 32'(ref_retire));

    $display("[TB] back-to-back ALU writes");
    apply_stimulus(0, 1, 5'd1, 0, 0, 0, 32'h11);
    apply_stimulus(0, 1, 5'd2, 0, 0, 0, 32'h22);
    apply_stimulus(0, 1, 5'd3, 0, 0, 0, 32'h33);
    idle(3);
    check_output("retire_count b2b", retire_count, 32'(ref_retire));

    $display("[TB] late loads");
    apply_stimulus(1, 1, 5'd6, 0, 3, 0, 32'h0);
    mem_respond(3, 32'h80FF1234);
    apply_stimulus(1, 1, 5'd7, 1, 2, 1, 32'h0);
    mem_respond(3, 32'h80FF1234);
    idle(3);
    check_output("LB off3 value", ref_regs[6], 32'hFFFFFF80);
    check_output("LHU off2 value", ref_regs[7], 32'h000080FF);

    $display("[TB] rd0 and misaligned load");
    apply_stimulus(0, 1, 5'd0, 0, 0, 0, 32'h1234);
    apply_stimulus(1, 1, 5'd8, 1, 1, 0, 32'h0);
    idle(3);
    check_output("retire_count rd0/misalign", retire_count, 32'(ref_retire));

    $display("[TB] reset during WAIT_MEM");
    apply_stimulus(1, 1, 5'd9, 2, 0, 0, 32'h0);
    idle(1);
    check_output("in_ready pending", 32'(wb.in_ready), 32'd0);
    @(negedge clock);
    reset_n    = 1'b0;
    ld_write   = 1'b0;
    ref_retire = 0;
    #1;
    check_output("in_ready in reset", 32'(wb.in_ready), 32'd1);
    check_output("retire_count in reset", retire_count, 32'd0);
    idle(2);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    wb.mem_rvalid = 1'b1;
    wb.mem_rdata  = 32'hCAFEF00D;
    idle(4);
    check_output("in_ready after stray rvalid", 32'(wb.in_ready), 32'd1);
    check_output("retire_count after stray", retire_count, 32'(ref_retire));

    $display("[TB] random traffic");
    for (int i = 0; i < 80; i++) begin
      int          kind, size, off;
      bit          rw, uns;
      logic [4:0]  rd;
      kind  = $urandom_range(0, 3);
      rd    = 5'($urandom_range(0, 31));
      rw    = ($urandom_range(0, 7) != 0);
      size  = $urandom_range(0, 2);
      off   = $urandom_range(0, 3);
      uns   = 1'($urandom_range(0, 1));
      rdata = $urandom;
      if (kind == 2) off = (size == 1) ? (off & 2) : (size == 2) ? 0 : off;
      if (kind < 2) begin
        apply_stimulus(0, rw, rd, 0, 0, 0, rdata);
      end else begin
        apply_stimulus(1, rw, rd, size, off, uns, 32'h0);
        if (!ref_misaligned(size, off)) mem_respond($urandom_range(0, 3), $urandom);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(5);
    check_output("retire_count final", retire_count, 32'(ref_retire));
    check_output("write queue drained", 32'(wr_q.size()), 32'd0);
    check_output("misalign queue drained", 32'(mis_q.size()), 32'd0);
    for (int r = 0; r < 32; r++) check_output($sformatf("bank r%0d", r), bank[r], ref_regs[r]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
